// File: rtl/vga_pkg.sv
// Shared VGA timing and framebuffer constants, plus the write-buffer types
// used by the VRAM access scheduler.
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;
    localparam int H_TOTAL   = 800;
    localparam int V_TOTAL   = 525;
    localparam int FB_W      = 160;
    localparam int FB_H      = 120;
    localparam int ADDR_W    = 15;
    localparam int DATA_W    = 4;

    typedef enum logic {WB_EMPTY, WB_PENDING} wbuf_state_t;
    typedef logic [DATA_W-1:0] colour_t;

endpackage

// File: rtl/vram_access_sched_if.sv
// Game-logic write channel into the framebuffer scheduler.
// The game side is the master; the scheduler is the slave and owns wr_ready.
interface vram_access_sched_if #(
    parameter int ADDR_W = vga_pkg::ADDR_W,
    parameter int DATA_W = vga_pkg::DATA_W
);
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    modport master (output wr_valid, wr_addr, wr_data, input  wr_ready);
    modport slave  (input  wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/fb_addr_calc.sv
// Screen cell -> framebuffer word address: fb_row * FB_W + fb_col.
// The constant multiply is built as a sum of shifted copies of fb_row,
// one per set bit of FB_W (for 160 that is <<7 + <<5), so no multiplier.
module fb_addr_calc #(
    parameter int ADDR_W = 15,
    parameter int FB_W   = 160
)(
    input  logic [7:0]        fb_col,
    input  logic [7:0]        fb_row,
    output logic [ADDR_W-1:0] addr
);
    logic [ADDR_W-1:0] row_w;
    logic [ADDR_W-1:0] col_w;
    logic [ADDR_W-1:0] row_scaled;

    assign row_w = ADDR_W'(fb_row);
    assign col_w = ADDR_W'(fb_col);

    // Shift-add constant multiply of the row index by FB_W
    always_comb begin
        row_scaled = '0;
        for (int b = 0; b < ADDR_W; b++) begin
            if (FB_W[b]) row_scaled = row_scaled + (row_w << b);
        end
    end

    assign addr = row_scaled + col_w;
endmodule

// File: rtl/vram_access_sched.sv
// Arbitrates the single-port framebuffer RAM between display scan-out and
// game writes. Scan-out owns the RAM whenever valid=1; a single game write
// is held in a one-entry buffer and committed on the first blanking cycle.
// Also delays the timing strobes by one cycle to line up with RAM read data,
// and generates a once-per-frame tick plus a frame counter.
module vram_access_sched
    import vga_pkg::*;
#(
    parameter int ADDR_W   = vga_pkg::ADDR_W,
    parameter int DATA_W   = vga_pkg::DATA_W,
    parameter int FB_W     = vga_pkg::FB_W,
    parameter int V_ACTIVE = vga_pkg::V_VISIBLE
)(
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        col_count,
    input  logic [9:0]        row_count,
    input  logic              valid,
    input  logic              hsync_in,
    input  logic              vsync_in,
    vram_access_sched_if.slave wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              pix_valid,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              frame_tick,
    output logic [7:0]        frame_cnt
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    wbuf_state_t       state;
    wr_entry_t         held;
    logic [ADDR_W-1:0] disp_addr;
    logic              commit;
    logic              accept;
    logic              frame_hit;

    // Four screen pixels per framebuffer cell in each direction
    fb_addr_calc #(
        .ADDR_W (ADDR_W),
        .FB_W   (FB_W)
    ) u_addr (
        .fb_col (col_count[9:2]),
        .fb_row (row_count[9:2]),
        .addr   (disp_addr)
    );

    // Any blanking cycle drains the buffer; scan-out is never interrupted.
    // wr_ready is combinational on valid so a slot freed by this cycle's
    // commit can be refilled in the same cycle.
    assign commit      = (state == WB_PENDING) && !valid;
    assign wr.wr_ready = (state == WB_EMPTY) || commit;
    assign accept      = wr.wr_valid && wr.wr_ready;
    assign frame_hit   = (row_count == 10'(V_ACTIVE)) && (col_count == 10'd0);

    // RAM port mux: commit > scan-out read > idle at address 0
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (commit) begin
            mem_we    = 1'b1;
            mem_addr  = held.addr;
            mem_wdata = held.data;
        end else if (valid) begin
            mem_addr  = disp_addr;
        end
    end

    // Write buffer FSM: a same-cycle accept overwrites the entry being committed
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WB_EMPTY;
            held  <= '0;
        end else if (accept) begin
            state <= WB_PENDING;
            held  <= '{addr: wr.wr_addr, data: wr.wr_data};
        end else if (commit) begin
            state <= WB_EMPTY;
        end
    end

    // One-cycle copies of the timing strobes, aligned with RAM read data
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_valid <= 1'b0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            pix_valid <= valid;
            hsync_out <= hsync_in;
            vsync_out <= vsync_in;
        end
    end

    // Frame tick at the first vertical blanking pixel; counter moves with it
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_tick <= 1'b0;
            frame_cnt  <= 8'd0;
        end else begin
            frame_tick <= frame_hit;
            if (frame_hit) frame_cnt <= frame_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_vram_access_sched.sv
// Bench for vram_access_sched. The bench plays the VGA timing generator
// (jumping around the frame to keep runs short) and the game writer.
// Accepted writes are queued and popped/compared whenever mem_we fires.
module tb_vram_access_sched;
    import vga_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [9:0]        col_count = '0;
    logic [9:0]        row_count = '0;
    logic              valid = 1'b0;
    logic              hsync_in = 1'b1;
    logic              vsync_in = 1'b1;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              pix_valid, hsync_out, vsync_out, frame_tick;
    logic [7:0]        frame_cnt;

    int n_assert = 0;
    int n_fail = 0;
    int commit_cnt = 0;
    int tick_cnt = 0;
    bit mon_en = 1'b0;
    int prev_col = 0;
    int prev_row = 0;
    logic [ADDR_W+DATA_W-1:0] sb_q[$];

    vram_access_sched_if wr_bus ();

    vram_access_sched dut (
        .clk        (clk),
        .reset      (reset),
        .col_count  (col_count),
        .row_count  (row_count),
        .valid      (valid),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .wr         (wr_bus),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .pix_valid  (pix_valid),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .frame_tick (frame_tick),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic apply_pos(input int c, input int r);
        col_count = 10'(c);
        row_count = 10'(r);
        valid     = (c < H_VISIBLE) && (r < V_VISIBLE);
        hsync_in  = !(c >= 656 && c < 752);
        vsync_in  = !(r >= 490 && r < 492);
    endtask

    task automatic step();
        int c, r;
        @(posedge clk);
        #1;
        c = int'(col_count) + 1;
        r = int'(row_count);
        if (c == H_TOTAL) begin
            c = 0;
            r++;
            if (r == V_TOTAL) r = 0;
        end
        apply_pos(c, r);
    endtask

    task automatic drive_wr(input logic v, input int a, input int d);
        wr_bus.wr_valid = v;
        wr_bus.wr_addr  = ADDR_W'(a);
        wr_bus.wr_data  = DATA_W'(d);
    endtask

    // Scoreboard and frame-tick monitor, sampled mid-cycle
    task automatic monitor();
        logic [ADDR_W+DATA_W-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset && mon_en) begin
                if (mem_we === 1'b1) begin
                    commit_cnt++;
                    n_assert++;
                    if (valid) begin
                        n_fail++;
                        $display("FAIL commit_in_active: mem_we=1 at col=%0d row=%0d", col_count, row_count);
                    end
                    n_assert++;
                    if (sb_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_commit: addr=%h data=%h, expected no write", mem_addr, mem_wdata);
                    end else begin
                        e = sb_q.pop_front();
                        if ({mem_addr, mem_wdata} !== e) begin
                            n_fail++;
                            $display("FAIL commit_entry: got addr=%h data=%h, expected %h", mem_addr, mem_wdata, e);
                        end
                    end
                end
                if (wr_bus.wr_valid && wr_bus.wr_ready) sb_q.push_back({wr_bus.wr_addr, wr_bus.wr_data});
                if (frame_tick === 1'b1) begin
                    tick_cnt++;
                    n_assert++;
                    if (!(prev_row == V_VISIBLE && prev_col == 0)) begin
                        n_fail++;
                        $display("FAIL tick_position: tick after col=%0d row=%0d, expected col=0 row=480", prev_col, prev_row);
                    end
                end
            end
            prev_col = int'(col_count);
            prev_row = int'(row_count);
        end
    endtask

    task automatic test_reset();
        apply_pos(300, 200);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_assert++; if (wr_bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wr_ready: got %b expected 1", wr_bus.wr_ready); end
        n_assert++; if (mem_we !== 1'b0)         begin n_fail++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
        n_assert++; if (frame_cnt !== 8'd0)      begin n_fail++; $display("FAIL rst_frame_cnt: got %0d expected 0", frame_cnt); end
        n_assert++; if (hsync_out !== 1'b1)      begin n_fail++; $display("FAIL rst_hsync_out: got %b expected 1", hsync_out); end
        n_assert++; if (vsync_out !== 1'b1)      begin n_fail++; $display("FAIL rst_vsync_out: got %b expected 1", vsync_out); end
        n_assert++; if (pix_valid !== 1'b0)      begin n_fail++; $display("FAIL rst_pix_valid: got %b expected 0", pix_valid); end
        n_assert++; if (frame_tick !== 1'b0)     begin n_fail++; $display("FAIL rst_frame_tick: got %b expected 0", frame_tick); end
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_single_write();
        int bad = 0;
        step();
        apply_pos(10, 5);
        drive_wr(1'b1, 'h0123, 'hA);
        @(negedge clk);
        n_assert++; if (wr_bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL sw_accept_ready: got %b expected 1", wr_bus.wr_ready); end
        step();
        drive_wr(1'b0, 0, 0);
        for (int i = 0; i < 1000 && col_count != 10'd640; i++) begin
            @(negedge clk);
            if (wr_bus.wr_ready !== 1'b0 || mem_we !== 1'b0) bad++;
            step();
        end
        n_assert++; if (col_count != 10'd640) begin n_fail++; $display("FAIL sw_timeout: col=%0d expected 640", col_count); end
        n_assert++; if (bad != 0) begin n_fail++; $display("FAIL sw_held_active: %0d cycles with wr_ready/mem_we high, expected 0", bad); end
        @(negedge clk);
        n_assert++; if (mem_we !== 1'b1)         begin n_fail++; $display("FAIL sw_mem_we: got %b expected 1", mem_we); end
        n_assert++; if (mem_addr !== 15'h0123)   begin n_fail++; $display("FAIL sw_mem_addr: got %h expected 0123", mem_addr); end
        n_assert++; if (mem_wdata !== 4'hA)      begin n_fail++; $display("FAIL sw_mem_wdata: got %h expected a", mem_wdata); end
        n_assert++; if (wr_bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL sw_ready_commit: got %b expected 1", wr_bus.wr_ready); end
    endtask

    task automatic test_addr_boundary();
        step();
        apply_pos(0, 0);
        @(negedge clk);
        n_assert++; if (mem_addr !== 15'd0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL addr_origin: got addr=%0d we=%b expected 0/0", mem_addr, mem_we); end
        step();
        apply_pos(13, 9);
        @(negedge clk);
        n_assert++; if (mem_addr !== 15'd323) begin n_fail++; $display("FAIL addr_mid: got %0d expected 323", mem_addr); end
        step();
        apply_pos(639, 479);
        @(negedge clk);
        n_assert++; if (mem_addr !== 15'd19199 || mem_we !== 1'b0) begin n_fail++; $display("FAIL addr_max: got addr=%0d we=%b expected 19199/0", mem_addr, mem_we); end
        step();
        @(negedge clk);
        n_assert++; if (pix_valid !== 1'b1) begin n_fail++; $display("FAIL pix_valid_delay: got %b expected 1", pix_valid); end
        n_assert++; if (mem_addr !== 15'd0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL idle_blank: got addr=%0d we=%b expected 0/0", mem_addr, mem_we); end
        step();
        @(negedge clk);
        n_assert++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL pix_valid_fall: got %b expected 0", pix_valid); end
    endtask

    task automatic test_back_to_back();
        int c0;
        step();
        apply_pos(700, 10);
        c0 = commit_cnt;
        for (int k = 0; k < 3; k++) begin
            drive_wr(1'b1, 'h200 + k, k + 1);
            @(negedge clk);
            n_assert++; if (wr_bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: got %b expected 1", k, wr_bus.wr_ready); end
            if (k > 0) begin
                n_assert++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL b2b_commit%0d: got %b expected 1", k, mem_we); end
            end
            step();
        end
        drive_wr(1'b0, 0, 0);
        @(negedge clk);
        n_assert++; if (mem_we !== 1'b1 || wr_bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_last: got we=%b ready=%b expected 1/1", mem_we, wr_bus.wr_ready); end
        step();
        @(negedge clk);
        n_assert++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b expected 0", mem_we); end
        n_assert++; if (commit_cnt - c0 != 3) begin n_fail++; $display("FAIL b2b_count: got %0d commits expected 3", commit_cnt - c0); end
    endtask

    task automatic test_sync_delay();
        step();
        apply_pos(655, 10);
        step();
        @(negedge clk);
        n_assert++; if (hsync_out !== 1'b1) begin n_fail++; $display("FAIL hsync_hold: got %b expected 1", hsync_out); end
        step();
        @(negedge clk);
        n_assert++; if (hsync_out !== 1'b0) begin n_fail++; $display("FAIL hsync_fall: got %b expected 0", hsync_out); end
        apply_pos(799, 489);
        step();
        @(negedge clk);
        n_assert++; if (vsync_out !== 1'b1) begin n_fail++; $display("FAIL vsync_hold: got %b expected 1", vsync_out); end
        step();
        @(negedge clk);
        n_assert++; if (vsync_out !== 1'b0) begin n_fail++; $display("FAIL vsync_fall: got %b expected 0", vsync_out); end
    endtask

    task automatic test_frames();
        int t0;
        t0 = tick_cnt;
        step();
        apply_pos(799, 479);
        step();
        @(negedge clk);
        n_assert++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL tick_early: got %b expected 0", frame_tick); end
        step();
        @(negedge clk);
        n_assert++; if (frame_tick !== 1'b1 || frame_cnt !== 8'd1) begin n_fail++; $display("FAIL tick_first: got tick=%b cnt=%0d expected 1/1", frame_tick, frame_cnt); end
        step();
        @(negedge clk);
        n_assert++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL tick_width: got %b expected 0", frame_tick); end
        apply_pos(795, 524);
        repeat (10) step();
        apply_pos(790, 479);
        repeat (20) step();
        @(negedge clk);
        n_assert++; if (tick_cnt - t0 != 2) begin n_fail++; $display("FAIL tick_count: got %0d expected 2", tick_cnt - t0); end
        n_assert++; if (frame_cnt !== 8'd2) begin n_fail++; $display("FAIL frame_cnt2: got %0d expected 2", frame_cnt); end
    endtask

    task automatic test_frame_wrap();
        for (int i = 0; i < 253; i++) begin
            step();
            apply_pos(0, 480);
            step();
        end
        @(negedge clk);
        n_assert++; if (frame_cnt !== 8'd255) begin n_fail++; $display("FAIL frame_cnt255: got %0d expected 255", frame_cnt); end
        step();
        apply_pos(0, 480);
        step();
        @(negedge clk);
        n_assert++; if (frame_tick !== 1'b1 || frame_cnt !== 8'd0) begin n_fail++; $display("FAIL frame_wrap: got tick=%b cnt=%0d expected 1/0", frame_tick, frame_cnt); end
    endtask

    task automatic test_reset_discard();
        int c0;
        step();
        apply_pos(100, 20);
        drive_wr(1'b1, 'h0055, 'h3);
        @(negedge clk);
        step();
        drive_wr(1'b0, 0, 0);
        reset = 1'b1;
        step();
        step();
        sb_q.delete();
        reset = 1'b0;
        apply_pos(640, 20);
        c0 = commit_cnt;
        @(negedge clk);
        n_assert++; if (mem_we !== 1'b0 || wr_bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL discard_first: got we=%b ready=%b expected 0/1", mem_we, wr_bus.wr_ready); end
        repeat (20) step();
        @(negedge clk);
        n_assert++; if (commit_cnt != c0) begin n_fail++; $display("FAIL discard_commits: got %0d expected 0", commit_cnt - c0); end
    endtask

    initial begin
        drive_wr(1'b0, 0, 0);
        fork
            monitor();
        join_none
        test_reset();
        test_single_write();
        test_addr_boundary();
        test_back_to_back();
        test_sync_delay();
        test_frames();
        test_frame_wrap();
        test_reset_discard();
        n_assert++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d writes never committed, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
